// File: rtl/buffer_pingpong_ctrl.sv
// Ping-pong tile buffer controller: steers a producer stream into two banks
// tile by tile and presents the completed bank to a consumer for random
// access reads until the consumer releases it.
module buffer_pingpong_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int TILE_LEN     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [1:0]            bank_wr_en,
    output logic [ADDR_WIDTH-1:0] bank_wr_addr,
    output logic [DATA_WIDTH-1:0] bank_wr_data,
    output logic [1:0]            bank_rd_en,
    output logic [ADDR_WIDTH-1:0] bank_rd_addr,
    input  logic [DATA_WIDTH-1:0] bank0_data_out,
    input  logic [DATA_WIDTH-1:0] bank1_data_out,
    output logic                  cons_tile_avail,
    input  logic                  cons_rd_en,
    input  logic [ADDR_WIDTH-1:0] cons_rd_addr,
    output logic [DATA_WIDTH-1:0] cons_data_out,
    input  logic                  cons_done,
    output logic                  done_err,
    output logic [15:0]           tile_cnt
);

    // A tile can never be longer than a bank; clamp so an out-of-range
    // TILE_LEN cannot overrun the bank address space.
    localparam int TILE_EFF = (TILE_LEN > BUFFER_DEPTH) ? BUFFER_DEPTH :
                              ((TILE_LEN < 1) ? 1 : TILE_LEN);
    localparam logic [ADDR_WIDTH-1:0] TILE_LAST  = ADDR_WIDTH'(TILE_EFF - 1);
    localparam logic [ADDR_WIDTH:0]   TILE_LIMIT = (ADDR_WIDTH + 1)'(TILE_EFF);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    bank_state_e           state_q [2];
    bank_state_e           state_d [2];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [15:0]           tile_cnt_q, tile_cnt_d;
    logic                  done_err_q, done_err_d;

    logic accept;
    logic avail;
    logic release_tile;
    logic rd_ok;

    // Handshake and bank port steering; everything is gated by reset so the
    // banks see no traffic while the controller is held in reset.
    always_comb begin
        avail        = rst && (state_q[rd_bank_q] == BANK_FULL);
        in_ready     = rst && (state_q[wr_bank_q] != BANK_FULL);
        accept       = in_valid && in_ready;
        release_tile = cons_done && avail;
        rd_ok        = cons_rd_en && avail && ({1'b0, cons_rd_addr} < TILE_LIMIT);

        cons_tile_avail = avail;
        bank_wr_en      = accept ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
        bank_wr_addr    = wr_cnt_q;
        bank_wr_data    = in_data;
        bank_rd_en      = rd_ok ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
        bank_rd_addr    = cons_rd_addr;
        cons_data_out   = rd_ok ? (rd_bank_q ? bank1_data_out : bank0_data_out)
                                : '0;
        done_err        = done_err_q;
        tile_cnt        = tile_cnt_q;
    end

    // Next state: tile completion on wr_bank and release of rd_bank are
    // independent; wr_bank is never FULL when accepting, so they never collide.
    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        tile_cnt_d = tile_cnt_q;
        done_err_d = cons_done && !avail;

        if (accept) begin
            if (wr_cnt_q == TILE_LAST) begin
                state_d[wr_bank_q] = BANK_FULL;
                wr_cnt_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                wr_cnt_d           = wr_cnt_q + ADDR_WIDTH'(1);
            end
        end

        if (release_tile) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
            tile_cnt_d         = tile_cnt_q + 16'd1;
        end
    end

    // Control registers; reset drops any partial tile but leaves bank data alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            tile_cnt_q <= 16'd0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            done_err_q <= done_err_d;
        end
    end

endmodule

// File: tb/tb_buffer_pingpong_ctrl.sv
// Directed bench for buffer_pingpong_ctrl: one instance with TILE_LEN=4 for
// the functional scenarios, one with TILE_LEN=1 to reach the tile counter wrap.
module tb_buffer_pingpong_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int TL    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          rst, in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    bank_wr_en, bank_rd_en;
    logic [AW-1:0] bank_wr_addr, bank_rd_addr, cons_rd_addr;
    logic [DW-1:0] bank_wr_data, bank0_data_out, bank1_data_out, cons_data_out;
    logic          cons_tile_avail, cons_rd_en, cons_done, done_err;
    logic [15:0]   tile_cnt;

    // Wrap instance signals
    logic          w_rst, w_valid, w_ready, w_avail, w_done, w_err;
    logic [1:0]    w_wr_en, w_rd_en;
    logic [AW-1:0] w_wr_addr, w_rd_addr;
    logic [DW-1:0] w_wr_data, w_data_out;
    logic [15:0]   w_tile_cnt;

    int total = 0;
    int bad   = 0;

    // Two behavioural banks with combinational read
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (bank_wr_en[0]) mem0[bank_wr_addr] <= bank_wr_data;
        if (bank_wr_en[1]) mem1[bank_wr_addr] <= bank_wr_data;
    end
    assign bank0_data_out = mem0[bank_rd_addr];
    assign bank1_data_out = mem1[bank_rd_addr];

    buffer_pingpong_ctrl #(
        .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .TILE_LEN(TL)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_data(bank_wr_data),
        .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
        .bank0_data_out(bank0_data_out), .bank1_data_out(bank1_data_out),
        .cons_tile_avail(cons_tile_avail), .cons_rd_en(cons_rd_en),
        .cons_rd_addr(cons_rd_addr), .cons_data_out(cons_data_out),
        .cons_done(cons_done), .done_err(done_err), .tile_cnt(tile_cnt)
    );

    buffer_pingpong_ctrl #(
        .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW), .TILE_LEN(1)
    ) u_wrap (
        .clk(clk), .rst(w_rst),
        .in_valid(w_valid), .in_ready(w_ready), .in_data(16'h5A5A),
        .bank_wr_en(w_wr_en), .bank_wr_addr(w_wr_addr), .bank_wr_data(w_wr_data),
        .bank_rd_en(w_rd_en), .bank_rd_addr(w_rd_addr),
        .bank0_data_out(16'h0000), .bank1_data_out(16'h0000),
        .cons_tile_avail(w_avail), .cons_rd_en(1'b0),
        .cons_rd_addr(6'd0), .cons_data_out(w_data_out),
        .cons_done(w_done), .done_err(w_err), .tile_cnt(w_tile_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One producer beat: drive at the falling edge, check steering before the rising edge
    task automatic push_chk(input logic [DW-1:0] d, input logic [1:0] en,
                            input logic [AW-1:0] a, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk({tag, "_rdy"},  {31'd0, in_ready}, 32'd1);
        chk({tag, "_en"},   {30'd0, bank_wr_en}, {30'd0, en});
        chk({tag, "_addr"}, {26'd0, bank_wr_addr}, {26'd0, a});
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_data = '0;
        cons_rd_en = 1'b1; cons_rd_addr = '0; cons_done = 1'b0;
        w_rst = 1'b0; w_valid = 1'b0; w_done = 1'b0;

        // Reset state with stimulus asserted
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en",    {30'd0, bank_wr_en}, 32'd0);
        chk("rst_rd_en",    {30'd0, bank_rd_en}, 32'd0);
        chk("rst_avail",    {31'd0, cons_tile_avail}, 32'd0);
        chk("rst_data",     {16'd0, cons_data_out}, 32'd0);
        chk("rst_tile_cnt", {16'd0, tile_cnt}, 32'd0);
        chk("rst_done_err", {31'd0, done_err}, 32'd0);
        rst = 1'b1; w_rst = 1'b1; in_valid = 1'b0; cons_rd_en = 1'b0;

        // Single tile into bank 0
        for (int i = 0; i < 4; i++) push_chk(16'hA0 + 16'(i), 2'b01, 6'(i), "t1_push");
        @(negedge clk);
        in_valid = 1'b0; cons_rd_en = 1'b1; cons_rd_addr = 6'd2;
        #1;
        chk("t1_avail", {31'd0, cons_tile_avail}, 32'd1);
        chk("t1_rd_en", {30'd0, bank_rd_en}, 32'd1);
        chk("t1_rd_data", {16'd0, cons_data_out}, 32'hA2);

        // Out-of-range read
        @(negedge clk);
        cons_rd_addr = 6'd4;
        #1;
        chk("oor_rd_en", {30'd0, bank_rd_en}, 32'd0);
        chk("oor_data",  {16'd0, cons_data_out}, 32'd0);

        // Release bank 0
        @(negedge clk);
        cons_rd_en = 1'b0; cons_done = 1'b1;
        @(negedge clk);
        cons_done = 1'b0;
        #1;
        chk("rel_tile_cnt", {16'd0, tile_cnt}, 32'd1);
        chk("rel_avail",    {31'd0, cons_tile_avail}, 32'd0);
        chk("rel_done_err", {31'd0, done_err}, 32'd0);

        // Illegal release
        @(negedge clk);
        cons_done = 1'b1;
        @(negedge clk);
        cons_done = 1'b0;
        #1;
        chk("ill_done_err", {31'd0, done_err}, 32'd1);
        chk("ill_tile_cnt", {16'd0, tile_cnt}, 32'd1);
        chk("ill_avail",    {31'd0, cons_tile_avail}, 32'd0);
        chk("ill_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("ill_done_err_clr", {31'd0, done_err}, 32'd0);

        // Reset mid-tile: two elements into bank 1, then reset
        push_chk(16'h11, 2'b10, 6'd0, "mr_push0");
        push_chk(16'h12, 2'b10, 6'd1, "mr_push1");
        @(negedge clk);
        in_data = 16'h13; rst = 1'b0;
        #1;
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_wr_en",    {30'd0, bank_wr_en}, 32'd0);
        @(negedge clk);
        #1;
        chk("mr_in_ready2", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("mr_tile_cnt", {16'd0, tile_cnt}, 32'd0);
        chk("mr_avail",    {31'd0, cons_tile_avail}, 32'd0);

        // Ping-pong backpressure: 8 elements fill both banks
        for (int i = 0; i < 8; i++)
            push_chk(16'hB0 + 16'(i), (i < 4) ? 2'b01 : 2'b10, 6'(i % 4), "bp_push");
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hB8;
        #1;
        chk("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_stall_en",  {30'd0, bank_wr_en}, 32'd0);
        @(negedge clk);
        cons_done = 1'b1;
        #1;
        chk("bp_rel_rdy_same", {31'd0, in_ready}, 32'd0);
        chk("bp_rel_avail",    {31'd0, cons_tile_avail}, 32'd1);
        @(negedge clk);
        cons_done = 1'b0;
        #1;
        chk("bp_b8_rdy",  {31'd0, in_ready}, 32'd1);
        chk("bp_b8_en",   {30'd0, bank_wr_en}, 32'd1);
        chk("bp_b8_addr", {26'd0, bank_wr_addr}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; cons_rd_en = 1'b1; cons_rd_addr = 6'd3;
        #1;
        chk("bp_tile_cnt", {16'd0, tile_cnt}, 32'd1);
        chk("bp_rd_en",    {30'd0, bank_rd_en}, 32'd2);
        chk("bp_rd_data",  {16'd0, cons_data_out}, 32'hB7);

        // Release bank 1 so rd_bank returns to the partially filled bank 0
        @(negedge clk);
        cons_rd_en = 1'b0; cons_done = 1'b1;
        @(negedge clk);
        cons_done = 1'b0;
        #1;
        chk("sim_pre_avail", {31'd0, cons_tile_avail}, 32'd0);
        chk("sim_pre_cnt",   {16'd0, tile_cnt}, 32'd2);
        for (int i = 1; i < 4; i++) push_chk(16'hC0 + 16'(i), 2'b01, 6'(i), "sim_c");
        for (int i = 0; i < 3; i++) push_chk(16'hD0 + 16'(i), 2'b10, 6'(i), "sim_d");

        // Bank 1 completes while bank 0 is released
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hD3; cons_done = 1'b1;
        #1;
        chk("sim_en",    {30'd0, bank_wr_en}, 32'd2);
        chk("sim_addr",  {26'd0, bank_wr_addr}, 32'd3);
        chk("sim_avail", {31'd0, cons_tile_avail}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; cons_done = 1'b0; cons_rd_en = 1'b1; cons_rd_addr = 6'd3;
        #1;
        chk("sim_tile_cnt", {16'd0, tile_cnt}, 32'd3);
        chk("sim_avail1",   {31'd0, cons_tile_avail}, 32'd1);
        chk("sim_rd_en",    {30'd0, bank_rd_en}, 32'd2);
        chk("sim_rd_data",  {16'd0, cons_data_out}, 32'hD3);
        @(negedge clk);
        cons_rd_en = 1'b0;
        push_chk(16'hE0, 2'b01, 6'd0, "sim_e0");
        @(negedge clk);
        in_valid = 1'b0;

        // Counter wrap on the TILE_LEN=1 instance: one release per cycle
        @(negedge clk);
        w_valid = 1'b1;
        @(negedge clk);
        w_done = 1'b1;
        #1;
        chk("wrap_start_cnt",   {16'd0, w_tile_cnt}, 32'd0);
        chk("wrap_start_avail", {31'd0, w_avail}, 32'd1);
        repeat (65535) @(negedge clk);
        #1;
        chk("wrap_ffff", {16'd0, w_tile_cnt}, 32'hFFFF);
        chk("wrap_err",  {31'd0, w_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("wrap_zero", {16'd0, w_tile_cnt}, 32'd0);
        w_done = 1'b0; w_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
